// File: rtl/pll_phase_stepper_if.sv
// Request channel into the PLL phase stepper: one phase-shift command per
// valid/ready handshake.
interface pll_phase_stepper_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [3:0] req_steps;
    logic       req_load;

    modport master (
        output req_valid,
        output req_sel,
        output req_dir,
        output req_steps,
        output req_load,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        input  req_dir,
        input  req_steps,
        input  req_load,
        output req_ready
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// Sequences PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG for a dynamic PLL phase shift,
// then waits for the PLL to report stable lock before signalling done.
module pll_phase_stepper #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STEP_CYC     = 4,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      locked,
    pll_phase_stepper_if.slave        req,
    output logic [1:0]                phasesel,
    output logic                      phasedir,
    output logic                      phasestep,
    output logic                      phaseloadreg,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned TmrMax = (SETUP_CYC > STEP_CYC) ? SETUP_CYC : STEP_CYC;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned SetW   = $clog2(SETTLE_CYC + 1);
    localparam int unsigned ToW    = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [TmrW-1:0] SetupLast  = TmrW'(SETUP_CYC - 1);
    localparam logic [TmrW-1:0] StepLast   = TmrW'(STEP_CYC - 1);
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);
    localparam logic [ToW-1:0]  ToutLast   = ToW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStepLo,
        StStepHi,
        StLoadLo,
        StLoadHi,
        StSettle
    } state_e;

    state_e            state_q, state_d;
    logic              lock_meta_q, lock_s_q;
    logic [1:0]        sel_q, sel_d;
    logic              dir_q, dir_d;
    logic [3:0]        steps_q, steps_d;
    logic              load_q, load_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [ToW-1:0]    tout_q, tout_d;
    logic              phasestep_q, phasestep_d;
    logic              phaseload_q, phaseload_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_fire;
    logic              pulsing;

    assign req.req_ready = (state_q == StIdle) & lock_s_q & ~rst;
    assign req_fire      = req.req_valid & req.req_ready;
    assign pulsing       = state_q inside {StSetup, StStepLo, StStepHi, StLoadLo, StLoadHi};

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dir_d       = dir_q;
        steps_d     = steps_q;
        load_d      = load_q;
        tmr_d       = tmr_q;
        settle_d    = settle_q;
        tout_d      = tout_q;
        phasestep_d = phasestep_q;
        phaseload_d = phaseload_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        // Losing lock while touching the PLL controls abandons the shift at once.
        if (pulsing && !lock_s_q) begin
            state_d     = StIdle;
            err_d       = 1'b1;
            phasestep_d = 1'b1;
            phaseload_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        sel_d   = req.req_sel;
                        dir_d   = req.req_dir;
                        steps_d = req.req_steps;
                        load_d  = req.req_load;
                        tmr_d   = '0;
                        state_d = StSetup;
                    end
                end
                StSetup: begin
                    if (tmr_q == SetupLast) begin
                        tmr_d = '0;
                        if (steps_q != 4'd0) begin
                            state_d     = StStepLo;
                            phasestep_d = 1'b0;
                        end else if (load_q) begin
                            state_d     = StLoadLo;
                            phaseload_d = 1'b0;
                        end else begin
                            state_d  = StSettle;
                            settle_d = '0;
                            tout_d   = '0;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StStepLo: begin
                    if (tmr_q == StepLast) begin
                        tmr_d       = '0;
                        state_d     = StStepHi;
                        phasestep_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StStepHi: begin
                    if (tmr_q == StepLast) begin
                        tmr_d   = '0;
                        steps_d = steps_q - 1'b1;
                        if (steps_q > 4'd1) begin
                            state_d     = StStepLo;
                            phasestep_d = 1'b0;
                        end else if (load_q) begin
                            state_d     = StLoadLo;
                            phaseload_d = 1'b0;
                        end else begin
                            state_d  = StSettle;
                            settle_d = '0;
                            tout_d   = '0;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StLoadLo: begin
                    if (tmr_q == StepLast) begin
                        tmr_d       = '0;
                        state_d     = StLoadHi;
                        phaseload_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StLoadHi: begin
                    if (tmr_q == StepLast) begin
                        tmr_d    = '0;
                        state_d  = StSettle;
                        settle_d = '0;
                        tout_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StSettle: begin
                    tout_d   = tout_q + 1'b1;
                    settle_d = lock_s_q ? settle_q + 1'b1 : '0;
                    // Completion wins over a timeout landing on the same cycle.
                    if (lock_s_q && (settle_q == SettleLast)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (tout_q == ToutLast) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            sel_q       <= 2'b00;
            dir_q       <= 1'b1;
            steps_q     <= '0;
            load_q      <= 1'b0;
            tmr_q       <= '0;
            settle_q    <= '0;
            tout_q      <= '0;
            phasestep_q <= 1'b1;
            phaseload_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            steps_q     <= steps_d;
            load_q      <= load_d;
            tmr_q       <= tmr_d;
            settle_q    <= settle_d;
            tout_q      <= tout_d;
            phasestep_q <= phasestep_d;
            phaseload_q <= phaseload_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = phasestep_q;
    assign phaseloadreg = phaseload_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles that phasesel/phasedir are held stable before the first step pulse.
REQ-002 SHALL have parameter STEP_CYC, default 4: cycles of each low phase and each high phase of phasestep/phaseloadreg.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: consecutive synchronized-locked cycles required after the last pulse.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum SETTLE duration in cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port locked, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port req_valid, input, 1 bit: phase-shift request.
REQ-009 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both 1.
REQ-010 SHALL have port req_sel, input, 2 bits: PHASESEL code (00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP).
REQ-011 SHALL have port req_dir, input, 1 bit: PHASEDIR value, passed through unchanged.
REQ-012 SHALL have port req_steps, input, 4 bits: number of step pulses, 0..15.
REQ-013 SHALL have port req_load, input, 1 bit: issue one phaseloadreg pulse after the steps.
REQ-014 SHALL have ports phasesel (output, 2 bits), phasedir (output, 1 bit), phasestep (output, 1 bit, active-low pulse) and phaseloadreg (output, 1 bit, active-low pulse): drive the PLL.
REQ-015 SHALL have ports busy (output, 1 bit), done (output, 1 bit, 1-cycle pulse) and err (output, 1 bit, 1-cycle pulse).

Function
REQ-016 SHALL pass locked through a 2-flop synchronizer (reset 0) to form lock_s; all logic uses only lock_s.
REQ-017 SHALL implement states IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI, SETTLE.
REQ-018 SHALL assert req_ready = (state==IDLE) & lock_s & ~rst; busy = (state!=IDLE).
REQ-019 SHALL, on acceptance, register req_sel/req_dir/req_steps/req_load, drive phasesel/phasedir from those registers on the next cycle, and hold them constant until return to IDLE.
REQ-020 SHALL ignore all req_* inputs while req_ready is 0; there is no queueing.
REQ-021 SHALL transition SETUP->STEP_LO after SETUP_CYC cycles if steps>0, else ->LOAD_LO if load=1, else ->SETTLE.
REQ-022 SHALL drive phasestep 0 for STEP_CYC cycles (STEP_LO) and then 1 for STEP_CYC cycles (STEP_HI), decrementing the step count at the end of STEP_HI, and repeat while the count is >0.
REQ-023 SHALL, after the final STEP_HI, go to LOAD_LO/LOAD_HI (phaseloadreg 0 then 1, STEP_CYC each) if load=1, else to SETTLE.
REQ-024 SHALL in SETTLE count consecutive lock_s=1 cycles, resetting the count to 0 on lock_s=0; on reaching SETTLE_CYC it pulses done and goes to IDLE.
REQ-025 SHALL place the done pulse at cycle 1+SETUP_CYC+2*STEP_CYC*(steps+load)+SETTLE_CYC after the acceptance cycle (cycle 0), with lock_s held high.
REQ-026 SHALL, on lock_s=0 in SETUP, STEP_* or LOAD_*, abort: pulse err, return phasestep/phaseloadreg to 1 on the same edge, go to IDLE, and issue no done.
REQ-027 SHALL, when SETTLE total time reaches LOCK_TIMEOUT without completion, pulse err and go to IDLE.
REQ-028 SHALL never assert done and err in the same cycle, and SHALL never drive phasestep and phaseloadreg low simultaneously.
REQ-029 SHALL size all counters for the maximum parameter value with no wrap-around.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, force state IDLE; lock_s, req_ready, busy, done, err, phasesel, counters =0; phasedir, phasestep, phaseloadreg =1.
REQ-031 SHALL, on rst mid-operation, abandon the operation without issuing done or err, return phasestep to 1 on that same edge, and reassert req_ready no earlier than 2 cycles after rst falls.

Verification
REQ-032 SHALL cover: locked=1, req sel=01 dir=0 steps=3 load=0 -> 3 phasestep low pulses of 4 cycles each, phasesel=01 throughout, done at cycle 43.
REQ-033 SHALL cover: steps=0 load=1 -> no phasestep pulse, one 4-cycle phaseloadreg low pulse, done at cycle 27.
REQ-034 SHALL cover: locked dropped during the 2nd STEP_LO -> phasestep=1 on the next edge, err pulse, no done, req_ready stays 0 until 2 cycles after locked returns.
REQ-035 SHALL cover: locked low for the whole SETTLE -> err at 1024 cycles into SETTLE, and req_valid pulses while busy are ignored.
REQ-036 SHALL cover: rst asserted in STEP_HI with steps=15 -> all outputs at reset values on the next edge, and a new request accepted afterwards completes normally.
